// File: rtl/score_tracker.sv
// -----------------------------------------------------------------------------
// score_tracker
//
// Converts raw play events (target hits, collisions, start button) into the
// score / game-over information consumed by the master state machine. It keeps
// a lives counter with a post-collision immunity window and, optionally, a
// session high score.
//
// Optional feature macro: SCORE_TRACKER_HISCORE_EN
//   defined   -> High_score is a register holding the best score of the session
//   undefined -> High_score is tied to 4'd0
//
// Ports:
//   CLK           in   system clock
//   RESET_N       in   asynchronous active-low reset
//   Master_state  in   [1:0] 00 IDLE, 01 PLAY, 10 WIN, 11 OVER
//   Target_hit    in   level, high while head overlaps the target
//   Collision     in   level, high while head overlaps a wall or body
//   Start         in   debounced start/restart button
//   Current_score out  [3:0] registered score
//   Game_over     out  registered, high once lives are exhausted
//   Lives_left    out  [1:0] registered remaining lives
//   Score_event   out  one-cycle pulse on each score increment
//   High_score    out  [3:0] best score of the session
// -----------------------------------------------------------------------------
module score_tracker #(
   parameter int WIN_SCORE      = 10,
   parameter int LIVES          = 3,
   parameter int HOLDOFF_CYCLES = 50_000_000
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [1:0] Master_state,
   input  logic       Target_hit,
   input  logic       Collision,
   input  logic       Start,
   output logic [3:0] Current_score,
   output logic       Game_over,
   output logic [1:0] Lives_left,
   output logic       Score_event,
   output logic [3:0] High_score
);

   localparam logic [3:0]  WIN4   = 4'(WIN_SCORE);
   localparam logic [1:0]  LIVES2 = 2'(LIVES);
   localparam logic [25:0] HOLD26 = 26'(HOLDOFF_CYCLES);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_PLAY = 2'b01;

   // Previous-sample registers for the rising-edge detectors
   logic r_target_prev;
   logic r_coll_prev;
   logic r_start_prev;

   logic [3:0]  r_score;
   logic [1:0]  r_lives;
   logic        r_game_over;
   logic [25:0] r_holdoff;
   logic        r_score_event;

   logic [3:0]  w_score_next;
   logic [1:0]  w_lives_next;
   logic        w_game_over_next;
   logic [25:0] w_holdoff_next;
   logic        w_score_event_next;

   logic w_target_ev;
   logic w_coll_ev;
   logic w_start_ev;

   assign w_target_ev = Target_hit & ~r_target_prev;
   assign w_coll_ev   = Collision  & ~r_coll_prev;
   assign w_start_ev  = Start      & ~r_start_prev;

   always_comb begin
      w_score_next       = r_score;
      w_lives_next       = r_lives;
      w_game_over_next   = r_game_over;
      w_holdoff_next     = r_holdoff;
      w_score_event_next = 1'b0;

      if (Master_state == ST_IDLE) begin
         w_score_next     = 4'd0;
         w_lives_next     = LIVES2;
         w_game_over_next = 1'b0;
         w_holdoff_next   = 26'd0;
      end else if (Master_state == ST_PLAY) begin
         if (r_holdoff != 26'd0) begin
            w_holdoff_next = r_holdoff - 26'd1;
         end
         if (w_coll_ev) begin
            // A collision edge always swallows a same-edge target edge,
            // whether or not the collision itself is accepted.
            if (r_holdoff == 26'd0 && r_lives != 2'd0) begin
               w_lives_next   = r_lives - 2'd1;
               w_holdoff_next = HOLD26;
               if (r_lives == 2'd1) begin
                  w_game_over_next = 1'b1;
               end
            end
         end else if (w_target_ev && r_score < WIN4) begin
            w_score_next       = r_score + 4'd1;
            w_score_event_next = 1'b1;
         end
      end else begin
         // WIN / OVER: state frozen, only a restart is honoured
         if (w_start_ev) begin
            w_score_next     = 4'd0;
            w_lives_next     = LIVES2;
            w_game_over_next = 1'b0;
            w_holdoff_next   = 26'd0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_target_prev <= 1'b0;
         r_coll_prev   <= 1'b0;
         r_start_prev  <= 1'b0;
         r_score       <= 4'd0;
         r_lives       <= LIVES2;
         r_game_over   <= 1'b0;
         r_holdoff     <= 26'd0;
         r_score_event <= 1'b0;
      end else begin
         r_target_prev <= Target_hit;
         r_coll_prev   <= Collision;
         r_start_prev  <= Start;
         r_score       <= w_score_next;
         r_lives       <= w_lives_next;
         r_game_over   <= w_game_over_next;
         r_holdoff     <= w_holdoff_next;
         r_score_event <= w_score_event_next;
      end
   end

   assign Current_score = r_score;
   assign Game_over     = r_game_over;
   assign Lives_left    = r_lives;
   assign Score_event   = r_score_event;

`ifdef SCORE_TRACKER_HISCORE_EN
   logic [3:0] r_high_score;
   logic       w_hs_update;

   // Capture on the edge where the game ends, either by losing the last life
   // or by reaching the winning score.
   assign w_hs_update = (w_game_over_next & ~r_game_over) |
                        ((w_score_next == WIN4) & (r_score != WIN4));

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_high_score <= 4'd0;
      end else if (w_hs_update && (w_score_next > r_high_score)) begin
         r_high_score <= w_score_next;
      end
   end

   assign High_score = r_high_score;
`else
   assign High_score = 4'd0;
`endif

endmodule

// File: tb/tb_score_tracker.sv
module tb_score_tracker;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic [1:0] Master_state;
   logic       Target_hit;
   logic       Collision;
   logic       Start;
   logic [3:0] Current_score;
   logic       Game_over;
   logic [1:0] Lives_left;
   logic       Score_event;
   logic [3:0] High_score;

   int total = 0;
   int bad   = 0;
   int ev_cnt;

`ifdef SCORE_TRACKER_HISCORE_EN
   localparam bit HS_EN = 1'b1;
`else
   localparam bit HS_EN = 1'b0;
`endif

   score_tracker #(
      .WIN_SCORE      (10),
      .LIVES          (3),
      .HOLDOFF_CYCLES (8)
   ) dut (
      .CLK           (CLK),
      .RESET_N       (RESET_N),
      .Master_state  (Master_state),
      .Target_hit    (Target_hit),
      .Collision     (Collision),
      .Start         (Start),
      .Current_score (Current_score),
      .Game_over     (Game_over),
      .Lives_left    (Lives_left),
      .Score_event   (Score_event),
      .High_score    (High_score)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
      $display("check %s observed=%0d expected=%0d", tag, obs, expv);
   endtask

   task automatic target_pulse();
      Target_hit = 1'b1;
      tick();
      Target_hit = 1'b0;
      tick();
   endtask

   // Collision pulses spaced 10 edges apart, longer than the 8-cycle hold-off
   task automatic coll_pulse();
      Collision = 1'b1;
      tick();
      Collision = 1'b0;
      repeat (9) tick();
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      Master_state = 2'b00;
      Target_hit = 1'b0;
      Collision = 1'b0;
      Start = 1'b0;
      repeat (2) tick();
      RESET_N = 1'b1;
      Master_state = 2'b01;
   endtask

   initial begin
      RESET_N = 1'b0;
      Master_state = 2'b00;
      Target_hit = 1'b0;
      Collision = 1'b0;
      Start = 1'b0;
      repeat (2) tick();
      check("rst_score", 32'(Current_score), 0);
      check("rst_gameover", 32'(Game_over), 0);
      check("rst_lives", 32'(Lives_left), 3);
      check("rst_event", 32'(Score_event), 0);
      check("rst_high", 32'(High_score), 0);

      // IDLE ignores events
      RESET_N = 1'b1;
      target_pulse();
      check("idle_score", 32'(Current_score), 0);

      // Five separate pulses in PLAY
      Master_state = 2'b01;
      ev_cnt = 0;
      for (int i = 1; i <= 5; i++) begin
         Target_hit = 1'b1;
         tick();
         check("pulse_score", 32'(Current_score), 32'(i));
         check("pulse_event", 32'(Score_event), 1);
         Target_hit = 1'b0;
         tick();
         check("pulse_event_low", 32'(Score_event), 0);
      end

      // Held level counts once
      Target_hit = 1'b1;
      tick();
      check("held_first", 32'(Current_score), 6);
      ev_cnt = 0;
      for (int i = 0; i < 19; i++) begin
         tick();
         if (Score_event) ev_cnt++;
      end
      check("held_no_more_events", 32'(ev_cnt), 0);
      check("held_score", 32'(Current_score), 6);
      Target_hit = 1'b0;
      tick();

      // Saturation at WIN_SCORE
      repeat (4) target_pulse();
      check("win_score", 32'(Current_score), 10);
      check("win_high", 32'(High_score), HS_EN ? 10 : 0);
      Target_hit = 1'b1;
      tick();
      check("sat_score", 32'(Current_score), 10);
      check("sat_event", 32'(Score_event), 0);
      Target_hit = 1'b0;
      tick();

      // Collisions with hold-off = 8
      do_reset();
      Collision = 1'b1;
      tick();                       // edge k
      check("coll1_lives", 32'(Lives_left), 2);
      Collision = 1'b0;
      repeat (3) tick();
      Collision = 1'b1;
      tick();                       // edge k+4, inside hold-off
      check("coll_holdoff_ign", 32'(Lives_left), 2);
      Collision = 1'b0;
      repeat (5) tick();
      Collision = 1'b1;
      tick();                       // edge m = k+10
      check("coll2_lives", 32'(Lives_left), 1);
      check("coll2_gameover", 32'(Game_over), 0);
      Collision = 1'b0;
      repeat (7) tick();
      Collision = 1'b1;
      tick();                       // edge m+8, last ignored edge
      check("coll_holdoff_edge", 32'(Lives_left), 1);
      Collision = 1'b0;
      tick();                       // edge m+9
      Collision = 1'b1;
      tick();                       // edge m+10
      check("coll3_lives", 32'(Lives_left), 0);
      check("coll3_gameover", 32'(Game_over), 1);
      Collision = 1'b0;
      tick();

      // Simultaneous target and collision at score 3, lives 3
      do_reset();
      repeat (3) target_pulse();
      Start = 1'b1;
      tick();
      Start = 1'b0;
      tick();
      check("start_in_play", 32'(Current_score), 3);
      Target_hit = 1'b1;
      Collision = 1'b1;
      tick();
      check("simul_score", 32'(Current_score), 3);
      check("simul_lives", 32'(Lives_left), 2);
      check("simul_event", 32'(Score_event), 0);
      Target_hit = 1'b0;
      Collision = 1'b0;
      tick();

      // Game over at score 4, then restart from OVER
      do_reset();
      repeat (4) target_pulse();
      repeat (3) coll_pulse();
      check("over_gameover", 32'(Game_over), 1);
      check("over_high", 32'(High_score), HS_EN ? 4 : 0);
      Master_state = 2'b11;
      target_pulse();
      coll_pulse();
      check("over_frozen_score", 32'(Current_score), 4);
      check("over_frozen_lives", 32'(Lives_left), 0);
      Start = 1'b1;
      tick();
      check("restart_score", 32'(Current_score), 0);
      check("restart_lives", 32'(Lives_left), 3);
      check("restart_gameover", 32'(Game_over), 0);
      check("restart_high", 32'(High_score), HS_EN ? 4 : 0);
      Start = 1'b0;
      tick();

      // Asynchronous reset mid-PLAY at score 6, lives 1
      do_reset();
      repeat (6) target_pulse();
      repeat (2) coll_pulse();
      check("pre_async_score", 32'(Current_score), 6);
      check("pre_async_lives", 32'(Lives_left), 1);
      RESET_N = 1'b0;               // mid-cycle, no clock edge follows yet
      #1;
      check("async_score", 32'(Current_score), 0);
      check("async_lives", 32'(Lives_left), 3);
      check("async_gameover", 32'(Game_over), 0);
      check("async_high", 32'(High_score), 0);
      // Level already high at deassertion counts on the first edge
      Target_hit = 1'b1;
      #1;
      RESET_N = 1'b1;
      tick();
      check("post_rst_score", 32'(Current_score), 1);
      check("post_rst_event", 32'(Score_event), 1);
      Target_hit = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
